// File: rtl/merge_run_ctrl.sv
// merge_run_ctrl: sequencing controller for a 2-input streaming merger.
// Each cycle it compares the head keys of FIFOs A and B, dequeues the smaller
// (ties go to A) and tells the datapath where the captured record came from.
// An all-zero key marks the end of a run. Once one side has shown its
// sentinel, the other side drains alone. The two sentinels then leave
// together as a single merged sentinel.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_a_key, i_a_empty      head key / empty flag of FIFO A
//   i_b_key, i_b_empty      head key / empty flag of FIFO B
//   i_out_ready             downstream can take a record this cycle
//   o_deq_a, o_deq_b        combinational dequeue strobes
//   o_valid, o_sel_a, o_last registered capture strobes (one cycle after dequeue)
//   o_run_len               records in current run (sentinel excluded), saturating
//   o_runs_done             completed runs since reset, wrapping
//   o_err                   sticky run-length saturation flag
module merge_run_ctrl #(
    parameter int unsigned KEY_WIDTH = 80,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [KEY_WIDTH-1:0] i_a_key,
    input  logic                 i_a_empty,
    input  logic [KEY_WIDTH-1:0] i_b_key,
    input  logic                 i_b_empty,
    input  logic                 i_out_ready,
    output logic                 o_deq_a,
    output logic                 o_deq_b,
    output logic                 o_valid,
    output logic                 o_sel_a,
    output logic                 o_last,
    output logic [CNT_WIDTH-1:0] o_run_len,
    output logic [CNT_WIDTH-1:0] o_runs_done,
    output logic                 o_err
);

    typedef enum logic [1:0] {
        ST_MERGE   = 2'b00,
        ST_DRAIN_A = 2'b01,
        ST_DRAIN_B = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    state_t state_nxt;
    logic   za;
    logic   zb;
    logic   deq_a_raw;
    logic   deq_b_raw;
    logic   sel_a_nxt;
    logic   last_nxt;
    logic   fire;

    assign za = (i_a_key == '0);
    assign zb = (i_b_key == '0);

    // Next state and dequeue decision.
    always_comb begin
        state_nxt = state;
        deq_a_raw = 1'b0;
        deq_b_raw = 1'b0;
        sel_a_nxt = 1'b0;
        last_nxt  = 1'b0;
        case (state)
            // A's sentinel is parked at its head, so A's empty flag is ignored here.
            ST_DRAIN_B: begin
                if (!i_b_empty && i_out_ready) begin
                    if (zb) begin
                        deq_a_raw = 1'b1;
                        deq_b_raw = 1'b1;
                        sel_a_nxt = 1'b1;
                        last_nxt  = 1'b1;
                        state_nxt = ST_MERGE;
                    end else begin
                        deq_b_raw = 1'b1;
                    end
                end
            end
            ST_DRAIN_A: begin
                if (!i_a_empty && i_out_ready) begin
                    if (za) begin
                        deq_a_raw = 1'b1;
                        deq_b_raw = 1'b1;
                        sel_a_nxt = 1'b1;
                        last_nxt  = 1'b1;
                        state_nxt = ST_MERGE;
                    end else begin
                        deq_a_raw = 1'b1;
                        sel_a_nxt = 1'b1;
                    end
                end
            end
            // MERGE, and recovery from the unused encoding.
            default: begin
                state_nxt = ST_MERGE;
                if (!i_a_empty && !i_b_empty && i_out_ready) begin
                    if (za && zb) begin
                        deq_a_raw = 1'b1;
                        deq_b_raw = 1'b1;
                        sel_a_nxt = 1'b1;
                        last_nxt  = 1'b1;
                    end else if (za) begin
                        deq_b_raw = 1'b1;
                        state_nxt = ST_DRAIN_B;
                    end else if (zb) begin
                        deq_a_raw = 1'b1;
                        sel_a_nxt = 1'b1;
                        state_nxt = ST_DRAIN_A;
                    end else if (i_a_key <= i_b_key) begin
                        deq_a_raw = 1'b1;
                        sel_a_nxt = 1'b1;
                    end else begin
                        deq_b_raw = 1'b1;
                    end
                end
            end
        endcase
    end

    // Strobes are forced low while reset is held so no FIFO is popped.
    assign o_deq_a = deq_a_raw & i_rst_n;
    assign o_deq_b = deq_b_raw & i_rst_n;
    assign fire    = deq_a_raw | deq_b_raw;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_MERGE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture strobes and run counters, all aligned one cycle after the dequeue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_sel_a     <= 1'b0;
            o_last      <= 1'b0;
            o_run_len   <= '0;
            o_runs_done <= '0;
            o_err       <= 1'b0;
        end else begin
            o_valid <= fire;
            o_last  <= fire & last_nxt;
            if (fire) begin
                o_sel_a <= sel_a_nxt;
                if (last_nxt) begin
                    o_run_len   <= '0;
                    o_runs_done <= o_runs_done + CNT_ONE;
                end else if (o_run_len == CNT_MAX) begin
                    o_err <= 1'b1;
                end else begin
                    o_run_len <= o_run_len + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_merge_run_ctrl.sv
// Directed bench for merge_run_ctrl: FIFO contents are modelled as queues,
// expected dequeue/capture entries are queued when a scenario is loaded and
// consumed as the DUT fires. Counters use CNT_WIDTH=3 so saturation and
// run-count wrap are reachable.
module tb_merge_run_ctrl;

    localparam int unsigned KW = 80;
    localparam int unsigned CW = 3;
    localparam logic [KW-1:0] JUNK_KEY = 80'h1234;

    typedef struct packed {
        logic da;
        logic db;
        logic sa;
        logic l;
    } exp_t;

    logic          i_clk;
    logic          i_rst_n;
    logic [KW-1:0] i_a_key;
    logic          i_a_empty;
    logic [KW-1:0] i_b_key;
    logic          i_b_empty;
    logic          i_out_ready;
    logic          o_deq_a;
    logic          o_deq_b;
    logic          o_valid;
    logic          o_sel_a;
    logic          o_last;
    logic [CW-1:0] o_run_len;
    logic [CW-1:0] o_runs_done;
    logic          o_err;

    merge_run_ctrl #(.KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_a_key     (i_a_key),
        .i_a_empty   (i_a_empty),
        .i_b_key     (i_b_key),
        .i_b_empty   (i_b_empty),
        .i_out_ready (i_out_ready),
        .o_deq_a     (o_deq_a),
        .o_deq_b     (o_deq_b),
        .o_valid     (o_valid),
        .o_sel_a     (o_sel_a),
        .o_last      (o_last),
        .o_run_len   (o_run_len),
        .o_runs_done (o_runs_done),
        .o_err       (o_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int            total = 0;
    int            bad   = 0;
    logic [KW-1:0] qa[$];
    logic [KW-1:0] qb[$];
    exp_t          exp_q[$];
    int            m_len  = 0;
    int            m_done = 0;
    logic          m_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic lda(input int a[$]);
        foreach (a[i]) qa.push_back(KW'(a[i]));
    endtask

    task automatic ldb(input int b[$]);
        foreach (b[i]) qb.push_back(KW'(b[i]));
    endtask

    task automatic ex(input logic da, input logic db, input logic sa, input logic l);
        exp_t e;
        e.da = da;
        e.db = db;
        e.sa = sa;
        e.l  = l;
        exp_q.push_back(e);
    endtask

    task automatic ex_a(); ex(1'b1, 1'b0, 1'b1, 1'b0); endtask
    task automatic ex_b(); ex(1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic ex_s(); ex(1'b1, 1'b1, 1'b1, 1'b1); endtask

    task automatic drive(input logic rdy, input logic frc_a, input logic frc_b);
        i_out_ready = rdy;
        i_a_key     = (qa.size() > 0) ? qa[0] : JUNK_KEY;
        i_b_key     = (qb.size() > 0) ? qb[0] : JUNK_KEY;
        i_a_empty   = frc_a || (qa.size() == 0);
        i_b_empty   = frc_b || (qb.size() == 0);
    endtask

    task automatic check_counters();
        chk("run_len", 64'(o_run_len), 64'(m_len));
        chk("runs_done", 64'(o_runs_done), 64'(m_done));
        chk("err", 64'(o_err), 64'(m_err));
    endtask

    // One clock: drive at negedge, check strobes, then check capture after the edge.
    task automatic cycle(input logic rdy, input logic frc_a, input logic frc_b, input logic fire);
        exp_t e;
        logic f;
        e = '0;
        f = fire;
        drive(rdy, frc_a, frc_b);
        #1;
        if (f) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 64'(1), 64'(0));
                f = 1'b0;
            end else begin
                e = exp_q.pop_front();
            end
        end
        chk("deq_a", 64'(o_deq_a), 64'(e.da));
        chk("deq_b", 64'(o_deq_b), 64'(e.db));
        if (e.da && qa.size() > 0) void'(qa.pop_front());
        if (e.db && qb.size() > 0) void'(qb.pop_front());
        @(posedge i_clk);
        #1;
        chk("valid", 64'(o_valid), 64'(f));
        if (f) begin
            chk("sel_a", 64'(o_sel_a), 64'(e.sa));
            chk("last", 64'(o_last), 64'(e.l));
            if (e.l) begin
                m_len  = 0;
                m_done = (m_done + 1) % 8;
            end else if (m_len == 7) begin
                m_err = 1'b1;
            end else begin
                m_len++;
            end
        end
        check_counters();
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_out_ready = 1'b1;
        i_a_key     = '0;
        i_b_key     = '0;
        i_a_empty   = 1'b1;
        i_b_empty   = 1'b1;

        // Reset held with both FIFOs non-empty.
        lda('{1, 0});
        ldb('{2, 0});
        drive(1'b1, 1'b0, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_deq_a", 64'(o_deq_a), 64'(0));
        chk("rst_deq_b", 64'(o_deq_b), 64'(0));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_last", 64'(o_last), 64'(0));
        chk("rst_sel_a", 64'(o_sel_a), 64'(0));
        check_counters();
        i_rst_n = 1'b1;
        ex_a(); ex_b(); ex_s();
        run(3);

        // Basic merge.
        lda('{1, 4, 6, 0});
        ldb('{2, 3, 7, 0});
        ex_a(); ex_b(); ex_b(); ex_a(); ex_a(); ex_b(); ex_s();
        run(7);

        // Same merge with ready pattern 1,0,0 repeating.
        lda('{1, 4, 6, 0});
        ldb('{2, 3, 7, 0});
        ex_a(); ex_b(); ex_b(); ex_a(); ex_a(); ex_b(); ex_s();
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            cycle((c % 3) == 0, 1'b0, 1'b0, (c % 3) == 0);
        end
        chk("stall_drained", 64'(exp_q.size()), 64'(0));

        // A ends first: B drains alone.
        lda('{5, 0});
        ldb('{1, 2, 3, 9, 0});
        ex_b(); ex_b(); ex_b(); ex_a(); ex_b(); ex_s();
        run(6);

        // DRAIN_B ignores A's empty flag, sentinel still dequeues both.
        lda('{1, 0});
        ldb('{5, 6, 0});
        ex_a(); ex_b(); ex_b(); ex_s();
        run(2);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);

        // DRAIN_A mirror with B's empty flag forced.
        lda('{1, 2, 3, 0});
        ldb('{0});
        ex_a(); ex_a(); ex_a(); ex_s();
        run(1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);

        // B empty in MERGE stalls; then a tie goes to A.
        lda('{3, 0});
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        ldb('{3, 0});
        ex_a(); ex_b(); ex_s();
        run(3);

        // Both heads zero: one sentinel, run count wraps to 0.
        lda('{0});
        ldb('{0});
        ex_s();
        run(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Nine-record run saturates run length at 7.
        for (int k = 1; k <= 9; k++) qa.push_back(KW'(k));
        lda('{0});
        ldb('{0});
        for (int k = 0; k < 9; k++) ex_a();
        ex_s();
        run(10);
        chk("sat_err_sticky", 64'(o_err), 64'(1));
        lda('{1, 0});
        ldb('{0});
        ex_a(); ex_s();
        run(2);

        // Reset clears the sticky error and counters.
        lda('{2, 0});
        ldb('{0});
        drive(1'b1, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        m_len  = 0;
        m_done = 0;
        m_err  = 1'b0;
        chk("rst2_deq_a", 64'(o_deq_a), 64'(0));
        chk("rst2_valid", 64'(o_valid), 64'(0));
        check_counters();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        ex_a(); ex_s();
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
